// File: rtl/rc_filter_bank_sequencer.sv
// ---------------------------------------------------------------------------
// rc_filter_bank_sequencer
//
// Purpose:
//   A bank of NUM_CH first-order RC (exponential smoothing) low-pass filters.
//   On every audio sample strobe, each channel is updated as
//       out[k] <= out[k] + ((alpha[k] * (in[k] - out[k])) >>> 16)
//   One 18x17 signed multiplier is shared by every channel. The channels are
//   processed one after another by a small LOAD/MUL/ACC sequencer, so a full
//   sample takes 3*NUM_CH clock cycles.
//
// Ports:
//   clk           system clock
//   I_RST         synchronous, active-high reset
//   audio_clk_en  sample strobe, one clk wide
//   in            packed signed inputs, channel k at bits [16k+15:16k]
//   out           packed signed filtered outputs (registered), same packing
//   cfg_we        alpha write strobe
//   cfg_ch        channel index for the alpha write
//   cfg_alpha     unsigned Q16 alpha value (clamped to 65536 on write)
//   busy          high while a sample sequence is in progress
//   done          one-cycle pulse when the sequence finishes
//   overrun       sticky: a strobe arrived while a sequence was running
// ---------------------------------------------------------------------------
module rc_filter_bank_sequencer #(
    parameter int          NUM_CH     = 4,
    parameter logic [16:0] ALPHA_INIT = 17'd6186
) (
    input  logic                  clk,
    input  logic                  I_RST,
    input  logic                  audio_clk_en,
    input  logic [16*NUM_CH-1:0]  in,
    output logic [16*NUM_CH-1:0]  out,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_ch,
    input  logic [16:0]           cfg_alpha,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int              CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [16:0]     ALPHA_MAX = 17'd65536;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MUL,
        ACC
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CH_W-1:0] ch;
    logic [CH_W-1:0] ch_next;
    logic            busy_next;
    logic            done_next;
    logic            capture;

    // Per-channel storage: input snapshot, filter state and smoothing factor
    logic signed [15:0] snap    [NUM_CH];
    logic signed [15:0] out_reg [NUM_CH];
    logic        [16:0] alpha   [NUM_CH];

    // Pipeline registers between the three per-channel steps
    logic signed [16:0] diff_q;
    logic signed [33:0] prod_q;

    // Values belonging to the channel currently being processed
    logic signed [15:0] snap_cur;
    logic signed [15:0] out_cur;
    logic        [16:0] alpha_cur;
    logic signed [16:0] diff_calc;
    logic signed [17:0] mult_a;
    logic signed [34:0] mult_full;

    // Configuration write decode
    logic              cfg_in_range;
    logic [CH_W-1:0]   cfg_idx;
    logic [16:0]       cfg_alpha_clamped;

    // Bits of the wide product that the Q16 rescale intentionally drops
    logic unused_prod_bits;

    // -----------------------------------------------------------------------
    // Sequencer state register. Reset wins over everything, so a sequence
    // interrupted by reset never reaches its ACC step or its done pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (I_RST) begin
            state <= IDLE;
            ch    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            ch    <= ch_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Each channel takes LOAD -> MUL -> ACC; after the last
    // channel's ACC the sequencer returns to IDLE, drops busy and pulses done
    // in the same edge, so a new strobe can be taken the very next cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        ch_next    = ch;
        busy_next  = busy;
        done_next  = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (audio_clk_en) begin
                    capture    = 1'b1;
                    ch_next    = '0;
                    busy_next  = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = MUL;
            end
            MUL: begin
                state_next = ACC;
            end
            ACC: begin
                if (ch == CH_LAST) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    ch_next    = ch + 1'b1;
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Shared arithmetic. The difference is taken at 17 bits so that even the
    // extreme -32768 - 32767 case cannot overflow. Alpha is zero-extended to
    // 18 bits so that 65536 (unity) stays positive in the signed multiply.
    // -----------------------------------------------------------------------
    assign snap_cur  = snap[ch];
    assign out_cur   = out_reg[ch];
    assign alpha_cur = alpha[ch];

    assign diff_calc = {snap_cur[15], snap_cur} - {out_cur[15], out_cur};
    assign mult_a    = {1'b0, alpha_cur};
    assign mult_full = 35'(mult_a) * 35'(diff_q);

    assign unused_prod_bits = ^{mult_full[34], prod_q[33:32], prod_q[15:0]};

    // -----------------------------------------------------------------------
    // Alpha writes: out-of-range channel indices are dropped and oversized
    // values are limited to unity gain.
    // -----------------------------------------------------------------------
    assign cfg_in_range      = ({29'd0, cfg_ch} < 32'(NUM_CH));
    assign cfg_idx           = cfg_ch[CH_W-1:0];
    assign cfg_alpha_clamped = (cfg_alpha > ALPHA_MAX) ? ALPHA_MAX : cfg_alpha;

    // -----------------------------------------------------------------------
    // Datapath registers. The input snapshot decouples the running sequence
    // from later input changes. MUL reads alpha through a non-blocking
    // register, so a same-cycle config write to that channel only takes
    // effect on the following sample. Only the channel in ACC touches out.
    // The low 16 bits of (prod >>> 16) are exactly prod[31:16]; the add wraps.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (I_RST) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap[k]    <= '0;
                out_reg[k] <= '0;
                alpha[k]   <= ALPHA_INIT;
            end
            diff_q  <= '0;
            prod_q  <= '0;
            overrun <= 1'b0;
        end else begin
            if (capture) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    snap[k] <= in[16*k +: 16];
                end
            end
            if (state == LOAD) begin
                diff_q <= diff_calc;
            end
            if (state == MUL) begin
                prod_q <= mult_full[33:0];
            end
            if (state == ACC) begin
                out_reg[ch] <= out_reg[ch] + prod_q[31:16];
            end
            if (audio_clk_en && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if (cfg_we && cfg_in_range) begin
                alpha[cfg_idx] <= cfg_alpha_clamped;
            end
        end
    end

    // Repack the per-channel filter state onto the output bus
    for (genvar g = 0; g < NUM_CH; g++) begin : g_out_pack
        assign out[16*g +: 16] = out_reg[g];
    end

endmodule

// File: tb/tb_rc_filter_bank_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rc_filter_bank_sequencer
//
// Directed testbench for rc_filter_bank_sequencer with NUM_CH = 4.
// Expected values are hand-computed constants:
//   default alpha 6186, diff 10000 -> +943
//   default alpha 6186, diff  9057 -> +854
//   default alpha 6186, diff  8203 -> +774
//   alpha 32768: 1000 -> 500 -> 750 -> 875 ; -1000 -> -500
//   unity alpha : out equals in; 32767 -> -32768 in one sample
// ---------------------------------------------------------------------------
module tb_rc_filter_bank_sequencer;

    localparam int NUM_CH = 4;

    logic                 clk;
    logic                 I_RST;
    logic                 audio_clk_en;
    logic [16*NUM_CH-1:0] in_bus;
    logic [16*NUM_CH-1:0] out_bus;
    logic                 cfg_we;
    logic [2:0]           cfg_ch;
    logic [16:0]          cfg_alpha;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    int compareCount = 0;
    int failCount    = 0;

    rc_filter_bank_sequencer #(
        .NUM_CH     (NUM_CH),
        .ALPHA_INIT (17'd6186)
    ) dut (
        .clk          (clk),
        .I_RST        (I_RST),
        .audio_clk_en (audio_clk_en),
        .in           (in_bus),
        .out          (out_bus),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_alpha    (cfg_alpha),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung simulation
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Hold reset across two rising edges
    task automatic doReset();
        @(negedge clk);
        I_RST = 1'b1;
        @(negedge clk);
        @(negedge clk);
        I_RST = 1'b0;
    endtask

    // One-cycle alpha write
    task automatic writeAlpha(input logic [2:0] ch, input logic [16:0] value);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_alpha = value;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // Strobe one sample and wait (bounded) for the done pulse
    task automatic applyStimulus(input logic [63:0] lanes);
        logic seenDone;
        seenDone = 1'b0;
        @(negedge clk);
        in_bus       = lanes;
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                seenDone = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("done_seen", {63'd0, seenDone}, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int busyCycles;
        int doneEdge;
        int doneCount;

        I_RST        = 1'b0;
        audio_clk_en = 1'b0;
        in_bus       = '0;
        cfg_we       = 1'b0;
        cfg_ch       = '0;
        cfg_alpha    = '0;

        // ---------------- reset state ----------------
        doReset();
        checkOutput("rst_out",     out_bus, 64'd0);
        checkOutput("rst_busy",    {63'd0, busy}, 64'd0);
        checkOutput("rst_done",    {63'd0, done}, 64'd0);
        checkOutput("rst_overrun", {63'd0, overrun}, 64'd0);

        // ---------------- default alpha ----------------
        applyStimulus({48'd0, 16'd10000});
        checkOutput("default_alpha", out_bus, {48'd0, 16'd943});

        // ---------------- unity alpha, exact timing ----------------
        doReset();
        writeAlpha(3'd0, 17'd65536);
        writeAlpha(3'd1, 17'd65536);
        writeAlpha(3'd2, 17'd65536);
        writeAlpha(3'd3, 17'h1FFFF);
        @(negedge clk);
        in_bus       = {16'h8000, 16'h7FFF, 16'hF830, 16'h03E8};
        audio_clk_en = 1'b1;
        busyCycles   = 0;
        doneEdge     = -1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) audio_clk_en = 1'b0;
            if (busy) busyCycles++;
            if (done && doneEdge < 0) doneEdge = c - 1;
            if (c == 3) checkOutput("unity_lane0_before_E3", {48'd0, out_bus[15:0]}, 64'd0);
            if (c == 4) begin
                checkOutput("unity_lane0_at_E3", {48'd0, out_bus[15:0]}, 64'd1000);
                checkOutput("unity_lane1_held",  {48'd0, out_bus[31:16]}, 64'd0);
            end
        end
        checkOutput("unity_out",         out_bus, {16'h8000, 16'h7FFF, 16'hF830, 16'h03E8});
        checkOutput("unity_busy_cycles", 64'(busyCycles), 64'd12);
        checkOutput("unity_done_edge",   64'(doneEdge), 64'd12);

        // ---------------- half alpha ----------------
        doReset();
        writeAlpha(3'd0, 17'd32768);
        applyStimulus({48'd0, 16'd1000});
        checkOutput("half_1", {48'd0, out_bus[15:0]}, 64'd500);
        applyStimulus({48'd0, 16'd1000});
        checkOutput("half_2", {48'd0, out_bus[15:0]}, 64'd750);
        applyStimulus({48'd0, 16'd1000});
        checkOutput("half_3", out_bus, {48'd0, 16'd875});
        doReset();
        writeAlpha(3'd0, 17'd32768);
        applyStimulus({48'd0, 16'hFC18});
        checkOutput("half_neg", out_bus, {48'd0, 16'hFE0C});

        // ---------------- overrun ----------------
        doReset();
        @(negedge clk);
        in_bus       = {4{16'd10000}};
        audio_clk_en = 1'b1;
        doneCount    = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            audio_clk_en = 1'b0;
            if (c == 5) begin
                checkOutput("overrun_before", {63'd0, overrun}, 64'd0);
                in_bus       = {4{16'd20000}};
                audio_clk_en = 1'b1;
            end
            if (c == 7) checkOutput("overrun_set", {63'd0, overrun}, 64'd1);
            if (done) doneCount++;
        end
        checkOutput("overrun_sticky", {63'd0, overrun}, 64'd1);
        checkOutput("overrun_done_count", 64'(doneCount), 64'd1);
        checkOutput("overrun_out", out_bus, {4{16'd943}});

        // ---------------- reset mid-sequence ----------------
        doReset();
        checkOutput("overrun_cleared", {63'd0, overrun}, 64'd0);
        writeAlpha(3'd0, 17'd65536);
        writeAlpha(3'd1, 17'd65536);
        writeAlpha(3'd2, 17'd65536);
        writeAlpha(3'd3, 17'd65536);
        @(negedge clk);
        in_bus       = {4{16'd10000}};
        audio_clk_en = 1'b1;
        doneCount    = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            audio_clk_en = 1'b0;
            if (c == 4) I_RST = 1'b1;
            if (c == 5) I_RST = 1'b0;
            if (done) doneCount++;
        end
        checkOutput("midrst_out",  out_bus, 64'd0);
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst_done", 64'(doneCount), 64'd0);
        applyStimulus({4{16'd10000}});
        checkOutput("midrst_next", out_bus, {4{16'd943}});

        // ---------------- config race ----------------
        doReset();
        @(negedge clk);
        in_bus       = {4{16'd10000}};
        audio_clk_en = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            audio_clk_en = 1'b0;
            cfg_we       = 1'b0;
            if (c == 8) begin
                cfg_we    = 1'b1;
                cfg_ch    = 3'd2;
                cfg_alpha = 17'd0;
            end
        end
        cfg_we = 1'b0;
        checkOutput("race_old_alpha", out_bus, {4{16'd943}});
        applyStimulus({4{16'd10000}});
        checkOutput("race_new_alpha", out_bus,
                    {16'd1797, 16'd943, 16'd1797, 16'd1797});
        writeAlpha(3'd7, 17'd0);
        applyStimulus({4{16'd10000}});
        checkOutput("cfg_ch_out_of_range", out_bus,
                    {16'd2571, 16'd943, 16'd2571, 16'd2571});

        // ---------------- wrap ----------------
        doReset();
        writeAlpha(3'd0, 17'd65536);
        applyStimulus({48'd0, 16'h7FFF});
        checkOutput("wrap_start", {48'd0, out_bus[15:0]}, 64'h7FFF);
        applyStimulus({48'd0, 16'h8000});
        checkOutput("wrap_end", out_bus, {48'd0, 16'h8000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
